// File: rtl/el2_exu_noc_result_receiver.sv
// NoC result receiver: reassembles NFLIT flits into {tag,data} results and queues them in a DEPTH-entry FIFO.
// Optional build macro EL2_NOC_RX_PARITY_EN adds per-flit even parity checking (flit_par in, err_parity out).
module el2_exu_noc_result_receiver #(
   parameter int FLIT_W = 8,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 2,
   parameter int DEPTH  = 2
) (
   input  logic              clk_noc,
   input  logic              rst_l,
   input  logic              flush,
   input  logic              flit_valid,
   input  logic [FLIT_W-1:0] flit_data,
   input  logic              flit_last,
`ifdef EL2_NOC_RX_PARITY_EN
   input  logic              flit_par,
   output logic              err_parity,
`endif
   output logic              flit_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              err_framing
);

   localparam int PKT_W = DATA_W + TAG_W;
   localparam int NFLIT = (PKT_W + FLIT_W - 1) / FLIT_W;
   localparam int CW    = (NFLIT > 1) ? $clog2(NFLIT) : 1;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int QW    = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } res_t;

   logic [NFLIT-1:0][FLIT_W-1:0] pkt_q, pkt_nx;
   logic [NFLIT*FLIT_W-1:0]      pkt_flat;
   logic [CW-1:0]                cnt_q;
   logic                         rdy_en_q;
   logic                         err_framing_q;
   logic [QW-1:0]                count_q;
   logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
   res_t                         mem_q [DEPTH];
   res_t                         pkt_res;

   logic acc, at_end, frame_ok, frame_err, pkt_end, push, pop;
   logic unused_pkt_bits;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ready is held low until the first edge after reset release.
   assign flit_ready = rdy_en_q && (count_q < QW'(DEPTH));
   assign acc        = flit_valid && flit_ready && !flush;
   assign at_end     = (cnt_q == CW'(NFLIT - 1));
   assign frame_ok   = flit_last && at_end;
   assign frame_err  = acc && (flit_last != at_end);
   assign pkt_end    = frame_ok || frame_err;

   // The final flit is merged combinationally so the push happens on its own edge.
   for (genvar k = 0; k < NFLIT; k++) begin : g_flit
      assign pkt_nx[k] = (cnt_q == CW'(k)) ? flit_data : pkt_q[k];
   end

   assign pkt_flat        = pkt_nx;
   assign pkt_res         = res_t'(pkt_flat[PKT_W-1:0]);
   assign unused_pkt_bits = ^pkt_flat;

`ifdef EL2_NOC_RX_PARITY_EN
   logic par_bad_flit, pkt_bad, bad_q, err_parity_q;

   assign par_bad_flit = flit_par ^ (^flit_data);
   assign pkt_bad      = bad_q || par_bad_flit;
   assign push         = acc && frame_ok && !pkt_bad;
   assign err_parity   = err_parity_q;

   always_ff @(posedge clk_noc or negedge rst_l) begin
      if (!rst_l) begin
         bad_q        <= 1'b0;
         err_parity_q <= 1'b0;
      end else begin
         // Framing errors take precedence, so parity only reports on a well-framed end.
         err_parity_q <= acc && frame_ok && pkt_bad;
         if (flush)
            bad_q <= 1'b0;
         else if (acc)
            bad_q <= pkt_end ? 1'b0 : pkt_bad;
      end
   end
`else
   assign push = acc && frame_ok;
`endif

   assign pop         = out_valid && out_ready && !flush;
   assign out_valid   = (count_q != '0);
   assign out_data    = mem_q[rd_ptr_q].data;
   assign out_tag     = mem_q[rd_ptr_q].tag;
   assign err_framing = err_framing_q;

   always_ff @(posedge clk_noc or negedge rst_l) begin
      if (!rst_l) begin
         rdy_en_q      <= 1'b0;
         err_framing_q <= 1'b0;
         cnt_q         <= '0;
         pkt_q         <= '0;
      end else begin
         rdy_en_q      <= 1'b1;
         err_framing_q <= frame_err;
         if (flush)
            cnt_q <= '0;
         else if (acc)
            cnt_q <= pkt_end ? '0 : cnt_q + 1'b1;
         if (acc)
            pkt_q <= pkt_nx;
      end
   end

   always_ff @(posedge clk_noc or negedge rst_l) begin
      if (!rst_l) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push)
            wr_ptr_q <= inc_ptr(wr_ptr_q);
         if (pop)
            rd_ptr_q <= inc_ptr(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_noc or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= pkt_res;
      end
   end

endmodule

// File: tb/tb_el2_exu_noc_result_receiver.sv
// Randomized + directed bench for el2_exu_noc_result_receiver against a packet/queue-level reference model.
module tb_el2_exu_noc_result_receiver;

   localparam int FLIT_W = 8;
   localparam int DATA_W = 32;
   localparam int TAG_W  = 2;
   localparam int DEPTH  = 2;
   localparam int PKT_W  = DATA_W + TAG_W;
   localparam int NFLIT  = (PKT_W + FLIT_W - 1) / FLIT_W;

   logic              clk_noc = 1'b0;
   logic              rst_l = 1'b0;
   logic              flush = 1'b0;
   logic              flit_valid = 1'b0;
   logic [FLIT_W-1:0] flit_data = '0;
   logic              flit_last = 1'b0;
   logic              out_ready = 1'b0;
   logic              flit_ready, out_valid, err_framing;
   logic [DATA_W-1:0] out_data;
   logic [TAG_W-1:0]  out_tag;
`ifdef EL2_NOC_RX_PARITY_EN
   logic              flit_par = 1'b0;
   logic              err_parity;
`endif

   el2_exu_noc_result_receiver #(
      .FLIT_W(FLIT_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
   ) dut (
      .clk_noc    (clk_noc),
      .rst_l      (rst_l),
      .flush      (flush),
      .flit_valid (flit_valid),
      .flit_data  (flit_data),
      .flit_last  (flit_last),
`ifdef EL2_NOC_RX_PARITY_EN
      .flit_par   (flit_par),
      .err_parity (err_parity),
`endif
      .flit_ready (flit_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_tag    (out_tag),
      .err_framing(err_framing)
   );

   always #5 clk_noc = ~clk_noc;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: results queue plus the flits of the packet in flight.
   logic [PKT_W-1:0]        m_q[$];
   logic [NFLIT*FLIT_W-1:0] m_pkt;
   int                      m_k = 0;
   bit                      m_bad = 0, m_ef = 0, m_ep = 0, m_en = 0;

   function automatic bit m_ready();
      return m_en && (m_q.size() < DEPTH);
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_k = 0; m_bad = 0; m_ef = 0; m_ep = 0; m_en = 0;
   endtask

   task automatic m_clock();
      bit acc, pbad;
      acc  = flit_valid && m_ready() && !flush;
      m_ef = 0;
      m_ep = 0;
      if (!rst_l) begin
         m_reset();
         return;
      end
      m_en = 1;
      if (flush) begin
         m_q.delete();
         m_k = 0; m_bad = 0;
         return;
      end
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (acc) begin
         m_pkt[m_k*FLIT_W +: FLIT_W] = flit_data;
         pbad = m_bad;
`ifdef EL2_NOC_RX_PARITY_EN
         if (flit_par != ^flit_data) pbad = 1;
`endif
         if (flit_last && m_k == NFLIT-1) begin
            if (pbad) m_ep = 1;
            else      m_q.push_back(m_pkt[PKT_W-1:0]);
            m_k = 0; m_bad = 0;
         end else if (flit_last || m_k == NFLIT-1) begin
            m_ef = 1;
            m_k = 0; m_bad = 0;
         end else begin
            m_k++;
            m_bad = pbad;
         end
      end
   endtask

   task automatic check_outs();
      chk("flit_ready", flit_ready, m_ready());
      chk("out_valid", out_valid, m_q.size() > 0);
      if (!rst_l) begin
         chk("rst_data", out_data, 0);
         chk("rst_tag", out_tag, 0);
      end else if (m_q.size() > 0) begin
         chk("out_data", out_data, m_q[0][DATA_W-1:0]);
         chk("out_tag", out_tag, m_q[0][PKT_W-1:DATA_W]);
      end
      chk("err_framing", err_framing, m_ef);
`ifdef EL2_NOC_RX_PARITY_EN
      chk("err_parity", err_parity, m_ep);
`endif
   endtask

   task automatic step();
      @(posedge clk_noc);
      m_clock();
      @(negedge clk_noc);
      check_outs();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send_flit(input logic [FLIT_W-1:0] d, input bit l, input bit pe);
      bit done = 0;
      flit_valid = 1; flit_data = d; flit_last = l;
`ifdef EL2_NOC_RX_PARITY_EN
      flit_par = (^d) ^ pe;
`endif
      for (int n = 0; n < 100 && !done; n++) begin
         done = m_ready() && !flush;
         step();
      end
      flit_valid = 0;
      if (!done) chk("accept_timeout", done, 1);
   endtask

   task automatic send_pkt(input logic [PKT_W-1:0] p, input int pe_idx);
      logic [NFLIT*FLIT_W-1:0] pad;
      pad = '0;
      pad[PKT_W-1:0] = p;
      for (int k = 0; k < NFLIT; k++)
         send_flit(pad[k*FLIT_W +: FLIT_W], k == NFLIT-1, k == pe_idx);
   endtask

   task automatic do_reset();
      rst_l = 0;
      #1;
      m_reset();
      check_outs();
      step();
      rst_l = 1;
   endtask

   function automatic logic [PKT_W-1:0] rnd_pkt();
      return PKT_W'({$urandom, $urandom});
   endfunction

   initial begin
      logic [PKT_W-1:0] p0, p1, p2;
      m_reset();
      @(negedge clk_noc);
      check_outs();
      idle(2);
      rst_l = 1;
      check_outs();
      step();
      chk("ready_after_rst", flit_ready, 1);

      // Reference packet from known flits.
      out_ready = 1;
      send_flit(8'h78, 0, 0);
      send_flit(8'h56, 0, 0);
      send_flit(8'h34, 0, 0);
      send_flit(8'h12, 0, 0);
      send_flit(8'h02, 1, 0);
      chk("r35_valid", out_valid, 1);
      chk("r35_data", out_data, 32'h12345678);
      chk("r35_tag", out_tag, 2);
      idle(2);

      // Backpressure: two packets fill the FIFO, third stalls then drains.
      out_ready = 0;
      p0 = rnd_pkt(); p1 = rnd_pkt(); p2 = rnd_pkt();
      send_pkt(p0, -1);
      send_pkt(p1, -1);
      chk("r36_ready_low", flit_ready, 0);
      flit_valid = 1; flit_data = p2[FLIT_W-1:0]; flit_last = 0;
`ifdef EL2_NOC_RX_PARITY_EN
      flit_par = ^p2[FLIT_W-1:0];
`endif
      idle(3);
      chk("r36_stall_head", out_data, p0[DATA_W-1:0]);
      out_ready = 1;
      step();
      chk("r36_head1", out_data, p1[DATA_W-1:0]);
      send_pkt(p2, -1);
      chk("r36_head2", out_data, p2[DATA_W-1:0]);
      idle(3);
      chk("r36_empty", out_valid, 0);

      // Early flit_last.
      send_flit(8'hAA, 0, 0);
      send_flit(8'hBB, 0, 0);
      send_flit(8'hCC, 1, 0);
      chk("r37_ef", err_framing, 1);
      chk("r37_novalid", out_valid, 0);
      step();
      chk("r37_ef_once", err_framing, 0);
      p0 = rnd_pkt();
      send_pkt(p0, -1);
      chk("r37_data", out_data, p0[DATA_W-1:0]);
      idle(2);

      // Flush mid-packet with a result queued.
      out_ready = 0;
      send_pkt(rnd_pkt(), -1);
      for (int k = 0; k < 3; k++) send_flit(FLIT_W'($urandom), 0, 0);
      flit_valid = 1; flit_data = FLIT_W'($urandom); flit_last = 0; flush = 1;
      step();
      flush = 0; flit_valid = 0;
      chk("r38_flushed", out_valid, 0);
      out_ready = 1;
      p1 = rnd_pkt();
      send_pkt(p1, -1);
      chk("r38_data", out_data, p1[DATA_W-1:0]);
      chk("r38_tag", out_tag, p1[PKT_W-1:DATA_W]);
      idle(2);

      // Reset mid-packet.
      send_flit(8'h11, 0, 0);
      send_flit(8'h22, 0, 0);
      do_reset();
      chk("r39_ready", flit_ready, 0);
      step();
      p2 = rnd_pkt();
      send_pkt(p2, -1);
      chk("r39_data", out_data, p2[DATA_W-1:0]);
      idle(2);

`ifdef EL2_NOC_RX_PARITY_EN
      send_pkt(rnd_pkt(), 1);
      chk("r40_ep", err_parity, 1);
      chk("r40_novalid", out_valid, 0);
      p0 = rnd_pkt();
      send_pkt(p0, -1);
      chk("r40_data", out_data, p0[DATA_W-1:0]);
      idle(2);
`endif

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         flush      = ($urandom_range(0, 49) == 0);
         flit_valid = ($urandom_range(0, 3) != 0);
         flit_data  = FLIT_W'($urandom);
         flit_last  = ($urandom_range(0, 19) == 0) ? 1'($urandom_range(0, 1)) : (m_k == NFLIT-1);
         out_ready  = ($urandom_range(0, 2) != 0);
`ifdef EL2_NOC_RX_PARITY_EN
         flit_par   = (^flit_data) ^ ($urandom_range(0, 29) == 0);
`endif
         if ($urandom_range(0, 599) == 0) do_reset();
         else step();
      end
      flush = 0; flit_valid = 0;
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
